// File: rtl/mips_pkg.sv
// mips_pkg: shared definitions for the multicycle MIPS control sequencer.
//   - opcode / funct field encodings of the supported instructions
//   - ALUControl encodings driven to the datapath ALU
//   - sequencer state encoding (also exported on the debug state port)
package mips_pkg;

  // instruction[31:26]
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;

  // instruction[5:0] for R-type
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_NOR = 6'b100111;
  localparam logic [5:0] FN_SLT = 6'b101010;

  // ALUControl
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_BRANCH = 3'd5,
    ST_JUMP   = 3'd6,
    ST_TRAP   = 3'd7
  } state_t;

  // lw/sw go through the MEM state after EXEC
  function automatic logic is_mem_op(input logic [5:0] op);
    return (op == OP_LW) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/mips_multicycle_ctrl_if.sv
// mips_multicycle_ctrl_if: controller <-> datapath bundle.
//   master (controller): consumes In_Opcode / In_Funct / In_Is0, drives all
//                        control strobes and mux selects.
//   slave  (datapath)  : the mirror image.
// Timing contract: there is no valid/ready pair here. In_Opcode/In_Funct are
// sampled on the clock edge that ends the last FETCH cycle and are ignored
// afterwards until the next fetch; In_Is0 is looked at combinationally only
// during the branch-resolve cycle. Every strobe is valid for the whole cycle
// it is asserted in and acts on the next rising clock edge.
interface mips_multicycle_ctrl_if;
  logic [5:0] In_Opcode;
  logic [5:0] In_Funct;
  logic       In_Is0;
  logic       PCWrite;
  logic       RegDst;
  logic       ALUSrc;
  logic       MemToReg;
  logic       PCSrc;
  logic       JumpPC;
  logic       RegWrite;
  logic       MemWrite;
  logic       MemRead;
  logic [3:0] ALUControl;

  modport master (
    input  In_Opcode, In_Funct, In_Is0,
    output PCWrite, RegDst, ALUSrc, MemToReg, PCSrc, JumpPC,
           RegWrite, MemWrite, MemRead, ALUControl
  );

  modport slave (
    output In_Opcode, In_Funct, In_Is0,
    input  PCWrite, RegDst, ALUSrc, MemToReg, PCSrc, JumpPC,
           RegWrite, MemWrite, MemRead, ALUControl
  );
endinterface

// File: rtl/mips_alu_decode.sv
// mips_alu_decode: combinational instruction classifier.
//   opcode, funct -> alu_ctrl : ALU operation for the execute / branch cycle
//                 -> legal    : 1 when opcode (and funct for R-type) is supported
module mips_alu_decode
  import mips_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output logic [3:0] alu_ctrl,
  output logic       legal
);

  always_comb begin
    alu_ctrl = ALU_ADD;
    legal    = 1'b1;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_ADD:  alu_ctrl = ALU_ADD;
          FN_SUB:  alu_ctrl = ALU_SUB;
          FN_AND:  alu_ctrl = ALU_AND;
          FN_OR:   alu_ctrl = ALU_OR;
          FN_NOR:  alu_ctrl = ALU_NOR;
          FN_SLT:  alu_ctrl = ALU_SLT;
          default: legal    = 1'b0;
        endcase
      end
      OP_ADDI, OP_LW, OP_SW: alu_ctrl = ALU_ADD;
      OP_SLTI:               alu_ctrl = ALU_SLT;
      OP_BEQ, OP_BNE:        alu_ctrl = ALU_SUB;
      OP_J:                  alu_ctrl = ALU_ADD;
      default:               legal    = 1'b0;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// mips_multicycle_ctrl: multicycle MIPS control sequencer.
//   CLK, Reset (async, active-low)
//   bus        : controller side of mips_multicycle_ctrl_if (opcode/funct/zero
//                in, all datapath strobes and selects out)
//   Halt       : high while trapped on an illegal instruction (sticky)
//   Cycle_Cnt  : cycles since reset, frozen while trapped
//   Instr_Cnt  : instructions retired (cycles with PCWrite=1)
//   dbg_state  : current sequencer state
// Parameters: FETCH_WAIT (0..15) extra fetch cycles, CNT_W counter width.
module mips_multicycle_ctrl
  import mips_pkg::*;
#(
  parameter int FETCH_WAIT = 1,
  parameter int CNT_W      = 32
) (
  input  logic                 CLK,
  input  logic                 Reset,
  mips_multicycle_ctrl_if.master bus,
  output logic                 Halt,
  output logic [CNT_W-1:0]     Cycle_Cnt,
  output logic [CNT_W-1:0]     Instr_Cnt,
  output state_t               dbg_state
);

  localparam logic [3:0] WAIT_INIT = 4'(FETCH_WAIT);

  state_t           state_q, state_d;
  logic [3:0]       wait_q, wait_d;
  logic [5:0]       op_q, op_d;
  logic [5:0]       fn_q, fn_d;
  logic [CNT_W-1:0] cyc_q, cyc_d;
  logic [CNT_W-1:0] icnt_q, icnt_d;

  logic [3:0] dec_alu;
  logic       dec_legal;
  logic       is_rtype;

  logic       pc_write, reg_dst, alu_src, mem_to_reg, pc_src, jump_pc;
  logic       reg_write, mem_write, mem_read;
  logic [3:0] alu_control;

  mips_alu_decode u_alu_decode (
    .opcode   (op_q),
    .funct    (fn_q),
    .alu_ctrl (dec_alu),
    .legal    (dec_legal)
  );

  assign is_rtype = (op_q == OP_RTYPE);

  always_comb begin
    state_d     = state_q;
    wait_d      = wait_q;
    op_d        = op_q;
    fn_d        = fn_q;
    pc_write    = 1'b0;
    reg_dst     = 1'b0;
    alu_src     = 1'b0;
    mem_to_reg  = 1'b0;
    pc_src      = 1'b0;
    jump_pc     = 1'b0;
    reg_write   = 1'b0;
    mem_write   = 1'b0;
    mem_read    = 1'b0;
    alu_control = ALU_AND;

    case (state_q)
      ST_FETCH: begin
        if (wait_q == 4'd0) begin
          // capture the instruction while leaving FETCH; the datapath may
          // change In_Opcode/In_Funct freely from here until the next fetch
          state_d = ST_DECODE;
          wait_d  = WAIT_INIT;
          op_d    = bus.In_Opcode;
          fn_d    = bus.In_Funct;
        end else begin
          wait_d = wait_q - 4'd1;
        end
      end
      ST_DECODE: begin
        if (!dec_legal)                          state_d = ST_TRAP;
        else if (op_q == OP_BEQ || op_q == OP_BNE) state_d = ST_BRANCH;
        else if (op_q == OP_J)                   state_d = ST_JUMP;
        else                                     state_d = ST_EXEC;
      end
      ST_EXEC: begin
        alu_control = dec_alu;
        alu_src     = !is_rtype;
        reg_dst     = is_rtype;
        state_d     = is_mem_op(op_q) ? ST_MEM : ST_WB;
      end
      ST_MEM: begin
        if (op_q == OP_LW) begin
          mem_read = 1'b1;
          state_d  = ST_WB;
        end else begin
          mem_write = 1'b1;
          pc_write  = 1'b1;
          state_d   = ST_FETCH;
        end
      end
      ST_WB: begin
        // the write-address mux must still point at rd while the register
        // file write happens, so RegDst stays up for R-type here
        reg_dst    = is_rtype;
        reg_write  = 1'b1;
        mem_to_reg = (op_q == OP_LW);
        pc_write   = 1'b1;
        state_d    = ST_FETCH;
      end
      ST_BRANCH: begin
        alu_control = ALU_SUB;
        pc_write    = 1'b1;
        pc_src      = (op_q == OP_BEQ) ? bus.In_Is0 : !bus.In_Is0;
        state_d     = ST_FETCH;
      end
      ST_JUMP: begin
        jump_pc  = 1'b1;
        pc_write = 1'b1;
        state_d  = ST_FETCH;
      end
      ST_TRAP: state_d = ST_TRAP;
      default: state_d = ST_FETCH;
    endcase

    cyc_d  = (state_q != ST_TRAP) ? cyc_q + CNT_W'(1) : cyc_q;
    icnt_d = pc_write ? icnt_q + CNT_W'(1) : icnt_q;
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state_q <= ST_FETCH;
      wait_q  <= WAIT_INIT;
      op_q    <= '0;
      fn_q    <= '0;
      cyc_q   <= '0;
      icnt_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      op_q    <= op_d;
      fn_q    <= fn_d;
      cyc_q   <= cyc_d;
      icnt_q  <= icnt_d;
    end
  end

  assign bus.PCWrite    = pc_write;
  assign bus.RegDst     = reg_dst;
  assign bus.ALUSrc     = alu_src;
  assign bus.MemToReg   = mem_to_reg;
  assign bus.PCSrc      = pc_src;
  assign bus.JumpPC     = jump_pc;
  assign bus.RegWrite   = reg_write;
  assign bus.MemWrite   = mem_write;
  assign bus.MemRead    = mem_read;
  assign bus.ALUControl = alu_control;

  assign Halt      = (state_q == ST_TRAP);
  assign Cycle_Cnt = cyc_q;
  assign Instr_Cnt = icnt_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Bench for mips_multicycle_ctrl. Two instances share clock, reset and
// instruction stimulus: u_dut0 (FETCH_WAIT=0, CNT_W=32) and u_dut_w
// (FETCH_WAIT=3, CNT_W=4, small enough to wrap both counters quickly).
// sel picks which instance the reference trace is compared against.
`timescale 1ns/1ps
module tb_mips_multicycle_ctrl;
  import mips_pkg::*;

  typedef struct packed {
    logic       pc_write;
    logic       reg_dst;
    logic       alu_src;
    logic       mem_to_reg;
    logic       pc_src;
    logic       jump_pc;
    logic       reg_write;
    logic       mem_write;
    logic       mem_read;
    logic [3:0] alu;
    logic       halt;
  } ctrl_t;
  localparam int CW = $bits(ctrl_t);

  typedef enum int {K_R, K_IMM, K_LW, K_SW, K_BR, K_J, K_ILL} kind_e;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [5:0] drv_op = '0;
  logic [5:0] drv_fn = '0;
  logic       drv_is0 = 1'b0;
  logic       sel = 1'b0;

  mips_multicycle_ctrl_if bus0 ();
  mips_multicycle_ctrl_if bus_w ();
  assign bus0.In_Opcode  = drv_op;
  assign bus0.In_Funct   = drv_fn;
  assign bus0.In_Is0     = drv_is0;
  assign bus_w.In_Opcode = drv_op;
  assign bus_w.In_Funct  = drv_fn;
  assign bus_w.In_Is0    = drv_is0;

  logic        halt0, halt_w;
  logic [31:0] cyc0, icnt0;
  logic [3:0]  cyc_w, icnt_w;
  state_t      st0, st_w;

  mips_multicycle_ctrl #(.FETCH_WAIT(0), .CNT_W(32)) u_dut0 (
    .CLK(clk), .Reset(rst_n), .bus(bus0), .Halt(halt0),
    .Cycle_Cnt(cyc0), .Instr_Cnt(icnt0), .dbg_state(st0)
  );

  mips_multicycle_ctrl #(.FETCH_WAIT(3), .CNT_W(4)) u_dut_w (
    .CLK(clk), .Reset(rst_n), .bus(bus_w), .Halt(halt_w),
    .Cycle_Cnt(cyc_w), .Instr_Cnt(icnt_w), .dbg_state(st_w)
  );

  ctrl_t obs0, obs_w, obs;
  logic [31:0] obs_cyc, obs_icnt;
  assign obs0 = {bus0.PCWrite, bus0.RegDst, bus0.ALUSrc, bus0.MemToReg, bus0.PCSrc,
                 bus0.JumpPC, bus0.RegWrite, bus0.MemWrite, bus0.MemRead,
                 bus0.ALUControl, halt0};
  assign obs_w = {bus_w.PCWrite, bus_w.RegDst, bus_w.ALUSrc, bus_w.MemToReg, bus_w.PCSrc,
                  bus_w.JumpPC, bus_w.RegWrite, bus_w.MemWrite, bus_w.MemRead,
                  bus_w.ALUControl, halt_w};
  assign obs      = sel ? obs_w : obs0;
  assign obs_cyc  = sel ? {28'd0, cyc_w} : cyc0;
  assign obs_icnt = sel ? {28'd0, icnt_w} : icnt0;

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int failures = 0;
  logic [CW-1:0] exp_q[$];
  logic [31:0] cyc_m, icnt_m;

  logic [5:0] legal_ops [8] = '{6'b000000, 6'b001000, 6'b001010, 6'b100011,
                                6'b101011, 6'b000100, 6'b000101, 6'b000010};
  logic [5:0] legal_fns [6] = '{6'b100000, 6'b100010, 6'b100100,
                                6'b100101, 6'b100111, 6'b101010};

  // ---------------- reference model ----------------
  function automatic kind_e classify(input logic [5:0] op, input logic [5:0] fn);
    case (op)
      6'b000000: return (fn inside {6'b100000, 6'b100010, 6'b100100,
                                    6'b100101, 6'b100111, 6'b101010}) ? K_R : K_ILL;
      6'b001000, 6'b001010: return K_IMM;
      6'b100011: return K_LW;
      6'b101011: return K_SW;
      6'b000100, 6'b000101: return K_BR;
      6'b000010: return K_J;
      default: return K_ILL;
    endcase
  endfunction

  function automatic logic [3:0] r_alu(input logic [5:0] fn);
    case (fn)
      6'b100000: return 4'b0010;
      6'b100010: return 4'b0110;
      6'b100100: return 4'b0000;
      6'b100101: return 4'b0001;
      6'b100111: return 4'b1100;
      default:   return 4'b0111;
    endcase
  endfunction

  // Expected per-cycle control word sequence for one instruction:
  // fw+1 fetch cycles, one decode cycle, then the class-specific tail.
  task automatic build_trace(input logic [5:0] op, input logic [5:0] fn,
                             input logic is0, input int fw);
    ctrl_t w;
    kind_e k = classify(op, fn);
    for (int i = 0; i < fw + 2; i++) exp_q.push_back('0);
    case (k)
      K_R: begin
        w = '0; w.alu = r_alu(fn); w.reg_dst = 1'b1; exp_q.push_back(w);
        w = '0; w.reg_dst = 1'b1; w.reg_write = 1'b1; w.pc_write = 1'b1; exp_q.push_back(w);
      end
      K_IMM: begin
        w = '0; w.alu = (op == 6'b001010) ? 4'b0111 : 4'b0010; w.alu_src = 1'b1; exp_q.push_back(w);
        w = '0; w.reg_write = 1'b1; w.pc_write = 1'b1; exp_q.push_back(w);
      end
      K_LW: begin
        w = '0; w.alu = 4'b0010; w.alu_src = 1'b1; exp_q.push_back(w);
        w = '0; w.mem_read = 1'b1; exp_q.push_back(w);
        w = '0; w.reg_write = 1'b1; w.mem_to_reg = 1'b1; w.pc_write = 1'b1; exp_q.push_back(w);
      end
      K_SW: begin
        w = '0; w.alu = 4'b0010; w.alu_src = 1'b1; exp_q.push_back(w);
        w = '0; w.mem_write = 1'b1; w.pc_write = 1'b1; exp_q.push_back(w);
      end
      K_BR: begin
        w = '0; w.alu = 4'b0110; w.pc_write = 1'b1;
        w.pc_src = (op == 6'b000100) ? is0 : !is0; exp_q.push_back(w);
      end
      K_J: begin
        w = '0; w.jump_pc = 1'b1; w.pc_write = 1'b1; exp_q.push_back(w);
      end
      default: begin
        for (int i = 0; i < 5; i++) begin
          w = '0; w.halt = 1'b1; exp_q.push_back(w);
        end
      end
    endcase
  endtask

  // ---------------- driver tasks ----------------
  // Enter at posedge+1 of the instruction's first cycle; leave at posedge+1
  // of the cycle after its last one.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic is0);
    int fw;
    int n;
    logic [31:0] mask;
    fw   = sel ? 3 : 0;
    mask = sel ? 32'h0000_000F : 32'hFFFF_FFFF;
    build_trace(op, fn, is0, fw);
    n = exp_q.size();
    for (int c = 0; c < n; c++) begin
      ctrl_t e;
      if (c <= fw) begin
        drv_op = op; drv_fn = fn;
      end else begin
        // after fetch the controller must ignore the instruction inputs
        drv_op = 6'($urandom); drv_fn = 6'($urandom);
      end
      drv_is0 = is0;
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL ctrl op=%b fn=%b is0=%0d cyc=%0d got=%h exp=%h", op, fn, is0, c + 1, obs, e);
      end
      checks++;
      if (obs_cyc !== (cyc_m & mask)) begin
        failures++;
        $display("FAIL cycle_cnt op=%b got=%0d exp=%0d", op, obs_cyc, cyc_m & mask);
      end
      checks++;
      if (obs_icnt !== (icnt_m & mask)) begin
        failures++;
        $display("FAIL instr_cnt op=%b got=%0d exp=%0d", op, obs_icnt, icnt_m & mask);
      end
      if (!e.halt) cyc_m++;
      if (e.pc_write) icnt_m++;
      @(posedge clk); #1;
    end
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    exp_q.delete();
    cyc_m = '0;
    icnt_m = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic rand_legal(output logic [5:0] op, output logic [5:0] fn);
    op = legal_ops[$urandom_range(0, 7)];
    fn = (op == 6'b000000) ? legal_fns[$urandom_range(0, 5)] : 6'($urandom);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    drv_op = 6'b100011;
    @(negedge clk);
    checks++;
    if (obs0 !== ctrl_t'('0) || obs_w !== ctrl_t'('0)) begin
      failures++;
      $display("FAIL reset_outputs got0=%h gotw=%h exp=0", obs0, obs_w);
    end
    checks++;
    if (cyc0 !== 32'd0 || icnt0 !== 32'd0 || cyc_w !== 4'd0 || icnt_w !== 4'd0) begin
      failures++;
      $display("FAIL reset_counters got=%0d/%0d/%0d/%0d exp=0", cyc0, icnt0, cyc_w, icnt_w);
    end
    checks++;
    if (st0 !== ST_FETCH || st_w !== ST_FETCH) begin
      failures++;
      $display("FAIL reset_state got=%0d/%0d exp=%0d", st0, st_w, ST_FETCH);
    end
    apply_reset();
  endtask

  task automatic test_directed();
    sel = 1'b0;
    apply_reset();
    run_instr(6'b000000, 6'b100000, 1'b0);      // add
    checks++;
    if (icnt0 !== 32'd1) begin
      failures++;
      $display("FAIL add_retire got=%0d exp=1", icnt0);
    end
    apply_reset();
    run_instr(6'b100011, 6'b000000, 1'b0);      // lw
    run_instr(6'b101011, 6'b000000, 1'b0);      // sw
    checks++;
    if (icnt0 !== 32'd2 || cyc0 !== 32'd9) begin
      failures++;
      $display("FAIL lw_sw got=%0d/%0d exp=2/9", icnt0, cyc0);
    end
    run_instr(6'b000100, 6'b000000, 1'b1);      // beq taken
    run_instr(6'b000101, 6'b000000, 1'b1);      // bne not taken
    run_instr(6'b000101, 6'b000000, 1'b0);      // bne taken
    run_instr(6'b000010, 6'b000000, 1'b0);      // j
  endtask

  task automatic test_random();
    logic [5:0] op, fn;
    sel = 1'b0;
    apply_reset();
    for (int i = 0; i < 60; i++) begin
      rand_legal(op, fn);
      run_instr(op, fn, 1'($urandom));
    end
    sel = 1'b1;
    apply_reset();
    for (int i = 0; i < 12; i++) begin
      rand_legal(op, fn);
      run_instr(op, fn, 1'($urandom));
    end
  endtask

  task automatic test_illegal();
    logic [5:0] op, fn;
    sel = 1'b0;
    apply_reset();
    run_instr(6'b111111, 6'b100000, 1'b0);
    checks++;
    if (cyc0 !== 32'd2 || halt0 !== 1'b1) begin
      failures++;
      $display("FAIL trap_freeze got cyc=%0d halt=%0d exp cyc=2 halt=1", cyc0, halt0);
    end
    apply_reset();
    run_instr(6'b000000, 6'b000001, 1'b0);
    for (int i = 0; i < 4; i++) begin
      apply_reset();
      do begin
        op = 6'($urandom); fn = 6'($urandom);
      end while (classify(op, fn) != K_ILL);
      rand_legal(drv_op, drv_fn);
      run_instr(legal_ops[i], legal_fns[i], 1'b0);   // a legal one first
      run_instr(op, fn, 1'b1);
    end
  endtask

  task automatic test_fetch_wait();
    sel = 1'b1;
    apply_reset();
    run_instr(6'b000000, 6'b100000, 1'b0);      // RegWrite in cycle 7
    run_instr(6'b100011, 6'b000000, 1'b0);
  endtask

  task automatic test_reset_mid();
    sel = 1'b0;
    apply_reset();
    drv_op = 6'b101011; drv_fn = '0; drv_is0 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    checks++;
    if (bus0.MemWrite !== 1'b1 || bus0.PCWrite !== 1'b1) begin
      failures++;
      $display("FAIL sw_mem_cycle got mw=%0d pcw=%0d exp 1/1", bus0.MemWrite, bus0.PCWrite);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (bus0.MemWrite !== 1'b0 || bus0.PCWrite !== 1'b0 || icnt0 !== 32'd0) begin
      failures++;
      $display("FAIL reset_mid got mw=%0d pcw=%0d icnt=%0d exp 0/0/0",
               bus0.MemWrite, bus0.PCWrite, icnt0);
    end
    @(posedge clk);
    #1;
    checks++;
    if (icnt0 !== 32'd0 || st0 !== ST_FETCH) begin
      failures++;
      $display("FAIL reset_mid_hold got icnt=%0d st=%0d exp 0/%0d", icnt0, st0, ST_FETCH);
    end
    apply_reset();
  endtask

  task automatic test_wrap();
    sel = 1'b1;
    apply_reset();
    for (int i = 0; i < 17; i++) run_instr(6'b000010, 6'b000000, 1'b0);
    @(negedge clk);
    checks++;
    if (icnt_w !== 4'd1 || cyc_w !== 4'd6) begin
      failures++;
      $display("FAIL counter_wrap got icnt=%0d cyc=%0d exp 1/6", icnt_w, cyc_w);
    end
    @(posedge clk); #1;
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_directed();
    test_random();
    test_illegal();
    test_fetch_wait();
    test_reset_mid();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
